// File: rtl/usb_tx_scheduler_pkg.sv
// Shared codes and types for the USB transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_tx_pkg;

    localparam logic [1:0] TX_NONE = 2'd0;
    localparam logic [1:0] TX_DATA = 2'd1;
    localparam logic [1:0] TX_ACK  = 2'd2;
    localparam logic [1:0] TX_NAK  = 2'd3;

    localparam int SIZE_W           = 7;
    localparam int MAX_DATA_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_e;

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Request/grant and transmitter command bundle around the TX scheduler.
// Latency: n/a (wiring only).
// Backpressure: requests are level-held until the matching grant pulse.
interface usb_tx_scheduler_if;
    import usb_tx_pkg::*;

    logic              hs_req;
    logic              hs_type;
    logic              data_req;
    logic [SIZE_W-1:0] data_size;
    logic              tx_done;
    logic [1:0]        tx_packet;
    logic [SIZE_W-1:0] tx_packet_data_size;
    logic              hs_grant;
    logic              data_grant;
    logic              hs_done;
    logic              data_done;
    logic              tx_error;
    logic              busy;

    // Scheduler side
    modport slave (
        input  hs_req, hs_type, data_req, data_size, tx_done,
        output tx_packet, tx_packet_data_size, hs_grant, data_grant,
               hs_done, data_done, tx_error, busy
    );

    // Requester / transmitter side
    modport master (
        output hs_req, hs_type, data_req, data_size, tx_done,
        input  tx_packet, tx_packet_data_size, hs_grant, data_grant,
               hs_done, data_done, tx_error, busy
    );

endinterface

// File: rtl/usb_tx_scheduler_flex_counter.sv
// Up-counter with sync clear that wraps at rollover_val.
// Latency: flag is combinational from the count register.
// Backpressure: none; count_enable gates advance.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= (count == rollover_val) ? '0 : count + NUM_CNT_BITS'(1);
        end
    end

    assign rollover_flag = count_enable && (count == rollover_val);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake vs data requests and sequences one USB TX packet at a time.
// Latency: request to command 1 cycle; all outputs registered.
// Backpressure: requests held until grant; none accepted outside IDLE.
module usb_tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int IPG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int MAX_DATA       = MAX_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_tx_scheduler_if.slave   bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > IPG_CYCLES) ? TIMEOUT_CYCLES : IPG_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    sched_state_e      state, state_nxt;
    logic [1:0]        cur_pkt, cur_pkt_nxt;
    logic [1:0]        tx_packet_q, tx_packet_nxt;
    logic [SIZE_W-1:0] size_q, size_nxt;
    logic              hs_grant_q, hs_grant_nxt;
    logic              data_grant_q, data_grant_nxt;
    logic              hs_done_q, hs_done_nxt;
    logic              data_done_q, data_done_nxt;
    logic              tx_error_q, tx_error_nxt;
    logic              busy_q, busy_nxt;

    logic              cnt_clear;
    logic              cnt_en;
    logic              cnt_flag;
    logic [CNT_W-1:0]  cnt_rollover;

    // One counter serves both the timeout and the gap; every state change reloads it.
    assign cnt_clear    = (state_nxt != state);
    assign cnt_en       = (state == ST_WAIT_DONE) || (state == ST_GAP);
    assign cnt_rollover = (state == ST_GAP) ? CNT_W'(IPG_CYCLES - 1)
                                            : CNT_W'(TIMEOUT_CYCLES - 1);

    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (cnt_rollover),
        .rollover_flag (cnt_flag)
    );

    always_comb begin
        state_nxt      = state;
        cur_pkt_nxt    = cur_pkt;
        tx_packet_nxt  = TX_NONE;
        size_nxt       = size_q;
        hs_grant_nxt   = 1'b0;
        data_grant_nxt = 1'b0;
        hs_done_nxt    = 1'b0;
        data_done_nxt  = 1'b0;
        tx_error_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.hs_req) begin
                    cur_pkt_nxt   = bus.hs_type ? TX_NAK : TX_ACK;
                    tx_packet_nxt = bus.hs_type ? TX_NAK : TX_ACK;
                    size_nxt      = '0;
                    hs_grant_nxt  = 1'b1;
                    state_nxt     = ST_START;
                end else if (bus.data_req) begin
                    data_grant_nxt = 1'b1;
                    if (bus.data_size <= SIZE_W'(MAX_DATA)) begin
                        cur_pkt_nxt   = TX_DATA;
                        tx_packet_nxt = TX_DATA;
                        size_nxt      = bus.data_size;
                        state_nxt     = ST_START;
                    end else begin
                        // Oversize request is granted only to be dropped.
                        tx_error_nxt = 1'b1;
                    end
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    hs_done_nxt   = (cur_pkt != TX_DATA);
                    data_done_nxt = (cur_pkt == TX_DATA);
                    size_nxt      = '0;
                    state_nxt     = ST_GAP;
                end else if (cnt_flag) begin
                    tx_error_nxt = 1'b1;
                    size_nxt     = '0;
                    state_nxt    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_flag) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            cur_pkt      <= TX_NONE;
            tx_packet_q  <= TX_NONE;
            size_q       <= '0;
            hs_grant_q   <= 1'b0;
            data_grant_q <= 1'b0;
            hs_done_q    <= 1'b0;
            data_done_q  <= 1'b0;
            tx_error_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur_pkt      <= cur_pkt_nxt;
            tx_packet_q  <= tx_packet_nxt;
            size_q       <= size_nxt;
            hs_grant_q   <= hs_grant_nxt;
            data_grant_q <= data_grant_nxt;
            hs_done_q    <= hs_done_nxt;
            data_done_q  <= data_done_nxt;
            tx_error_q   <= tx_error_nxt;
            busy_q       <= busy_nxt;
        end
    end

    assign bus.tx_packet           = tx_packet_q;
    assign bus.tx_packet_data_size = size_q;
    assign bus.hs_grant            = hs_grant_q;
    assign bus.data_grant          = data_grant_q;
    assign bus.hs_done             = hs_done_q;
    assign bus.data_done           = data_done_q;
    assign bus.tx_error            = tx_error_q;
    assign bus.busy                = busy_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: handshake, data, priority, oversize,
// timeout boundary and mid-packet reset, checked with immediate assertions.
module tb_usb_tx_scheduler;
    import usb_tx_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;
    int   err_seen;
    int   done_seen;
    int   gap_low;

    usb_tx_scheduler_if bus();

    usb_tx_scheduler #(
        .IPG_CYCLES     (16),
        .TIMEOUT_CYCLES (8192),
        .MAX_DATA       (64)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_rst         = 1'b0;
        bus.hs_req    = 1'b0;
        bus.hs_type   = 1'b0;
        bus.data_req  = 1'b0;
        bus.data_size = '0;
        bus.tx_done   = 1'b0;

        // Reset state
        #3;
        chk("rst_tx_packet", 32'(bus.tx_packet), 32'(TX_NONE));
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pulses", 32'({bus.hs_grant, bus.data_grant, bus.hs_done, bus.data_done, bus.tx_error}), 0);
        chk("rst_size", 32'(bus.tx_packet_data_size), 0);
        ticks(2);
        n_rst = 1'b1;
        tick();

        // NAK, tx_done 40 cycles after the command, 16-cycle gap
        bus.hs_req  = 1'b1;
        bus.hs_type = 1'b1;
        tick();
        chk("nak_cmd", 32'(bus.tx_packet), 32'(TX_NAK));
        chk("nak_grant", 32'(bus.hs_grant), 1);
        chk("nak_busy", 32'(bus.busy), 1);
        chk("nak_size", 32'(bus.tx_packet_data_size), 0);
        bus.hs_req = 1'b0;
        tick();
        chk("nak_cmd_clr", 32'(bus.tx_packet), 32'(TX_NONE));
        chk("nak_grant_clr", 32'(bus.hs_grant), 0);
        ticks(38);
        chk("nak_no_early_done", 32'(bus.hs_done), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("nak_done", 32'(bus.hs_done), 1);
        chk("nak_done_no_err", 32'(bus.tx_error), 0);
        chk("nak_done_busy", 32'(bus.busy), 1);
        gap_low = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (bus.busy !== 1'b1) gap_low++;
        end
        chk("nak_gap_busy", 32'(gap_low), 0);
        tick();
        chk("nak_gap_end_idle", 32'(bus.busy), 0);

        // DATA, max legal size
        bus.data_req  = 1'b1;
        bus.data_size = 7'd64;
        tick();
        chk("d64_cmd", 32'(bus.tx_packet), 32'(TX_DATA));
        chk("d64_grant", 32'(bus.data_grant), 1);
        chk("d64_size", 32'(bus.tx_packet_data_size), 64);
        bus.data_req = 1'b0;
        tick();
        chk("d64_cmd_clr", 32'(bus.tx_packet), 32'(TX_NONE));
        ticks(5);
        chk("d64_size_hold", 32'(bus.tx_packet_data_size), 64);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("d64_done", 32'(bus.data_done), 1);
        chk("d64_hs_done_quiet", 32'(bus.hs_done), 0);
        chk("d64_size_clr", 32'(bus.tx_packet_data_size), 0);
        ticks(16);
        chk("d64_idle", 32'(bus.busy), 0);

        // Simultaneous requests: ACK wins, DATA follows IPG+1 after hs_done
        bus.hs_req    = 1'b1;
        bus.hs_type   = 1'b0;
        bus.data_req  = 1'b1;
        bus.data_size = 7'd8;
        tick();
        chk("pri_ack_cmd", 32'(bus.tx_packet), 32'(TX_ACK));
        chk("pri_hs_grant", 32'(bus.hs_grant), 1);
        chk("pri_no_data_grant", 32'(bus.data_grant), 0);
        bus.hs_req  = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        tick();
        bus.tx_done = 1'b0;
        chk("pri_hs_done", 32'(bus.hs_done), 1);
        ticks(16);
        chk("pri_gap_no_cmd", 32'(bus.tx_packet), 32'(TX_NONE));
        chk("pri_gap_idle", 32'(bus.busy), 0);
        tick();
        chk("pri_data_cmd", 32'(bus.tx_packet), 32'(TX_DATA));
        chk("pri_data_grant", 32'(bus.data_grant), 1);
        chk("pri_data_size", 32'(bus.tx_packet_data_size), 8);
        bus.data_req = 1'b0;
        bus.tx_done  = 1'b1;
        tick();
        tick();
        bus.tx_done = 1'b0;
        chk("pri_data_done", 32'(bus.data_done), 1);
        ticks(16);

        // Oversize request is rejected in place
        bus.data_req  = 1'b1;
        bus.data_size = 7'd65;
        tick();
        chk("big_grant", 32'(bus.data_grant), 1);
        chk("big_err", 32'(bus.tx_error), 1);
        chk("big_no_cmd", 32'(bus.tx_packet), 32'(TX_NONE));
        chk("big_not_busy", 32'(bus.busy), 0);
        bus.data_req = 1'b0;
        tick();
        chk("big_pulses_clr", 32'({bus.data_grant, bus.tx_error}), 0);
        chk("big_still_idle", 32'(bus.busy), 0);

        // Timeout with a zero-length packet
        bus.data_req  = 1'b1;
        bus.data_size = 7'd0;
        tick();
        chk("to_cmd", 32'(bus.tx_packet), 32'(TX_DATA));
        chk("to_size0", 32'(bus.tx_packet_data_size), 0);
        bus.data_req = 1'b0;
        err_seen  = 0;
        done_seen = 0;
        for (int i = 0; i < 8192; i++) begin
            tick();
            err_seen  += int'(bus.tx_error);
            done_seen += int'(bus.data_done);
        end
        chk("to_no_early_err", 32'(err_seen), 0);
        chk("to_last_wait_busy", 32'(bus.busy), 1);
        tick();
        chk("to_err", 32'(bus.tx_error), 1);
        chk("to_no_done", 32'(done_seen + int'(bus.data_done)), 0);
        ticks(15);
        chk("to_gap_busy", 32'(bus.busy), 1);
        tick();
        chk("to_idle", 32'(bus.busy), 0);

        // tx_done on the final timeout cycle counts as success
        bus.data_req  = 1'b1;
        bus.data_size = 7'd5;
        tick();
        chk("fin_size", 32'(bus.tx_packet_data_size), 5);
        bus.data_req = 1'b0;
        err_seen = 0;
        for (int i = 0; i < 8192; i++) begin
            tick();
            err_seen += int'(bus.tx_error);
        end
        chk("fin_no_early_err", 32'(err_seen), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("fin_done", 32'(bus.data_done), 1);
        chk("fin_no_err", 32'(bus.tx_error), 0);
        ticks(16);
        chk("fin_idle", 32'(bus.busy), 0);

        // Reset in WAIT_DONE
        bus.data_req  = 1'b1;
        bus.data_size = 7'd33;
        tick();
        bus.data_req = 1'b0;
        ticks(4);
        chk("mrst_pre_size", 32'(bus.tx_packet_data_size), 33);
        chk("mrst_pre_busy", 32'(bus.busy), 1);
        n_rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_size", 32'(bus.tx_packet_data_size), 0);
        n_rst       = 1'b1;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("mrst_silent", 32'({bus.data_done, bus.hs_done, bus.tx_error, bus.busy}), 0);
        bus.hs_req  = 1'b1;
        bus.hs_type = 1'b0;
        tick();
        chk("mrst_ack_cmd", 32'(bus.tx_packet), 32'(TX_ACK));
        chk("mrst_ack_grant", 32'(bus.hs_grant), 1);
        bus.hs_req = 1'b0;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("mrst_ack_done", 32'(bus.hs_done), 1);
        ticks(16);
        chk("mrst_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Sits directly upstream of the USB transmitter and sequences it. It arbitrates between two requesters: the RX-side protocol logic, which requests handshake packets (ACK/NAK), and the AHB-side buffer, which requests DATA packets. It issues one packet command at a time on tx_packet/tx_packet_data_size, waits for tx_done, enforces a minimum inter-packet gap, and aborts on a transmit timeout.

Parameters:
IPG_CYCLES, 16, idle clk cycles enforced after each packet ends (done or timeout) before the next start
TIMEOUT_CYCLES, 8192, max clk cycles in WAIT_DONE before the packet is declared failed
MAX_DATA, 64, largest legal data payload in bytes

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
hs_req  in  1  handshake request, level; held until hs_grant
hs_type  in  1  0=ACK, 1=NAK; sampled with hs_req
data_req  in  1  data packet request, level; held until data_grant
data_size  in  7  payload byte count; sampled with data_req
tx_done  in  1  transmitter finished current packet (1-cycle pulse)
tx_packet  out  2  command to transmitter: 0=NONE, 1=DATA, 2=ACK, 3=NAK
tx_packet_data_size  out  7  payload size for the current DATA command
hs_grant  out  1  1-cycle pulse: handshake request accepted
data_grant  out  1  1-cycle pulse: data request accepted or rejected
hs_done  out  1  1-cycle pulse: handshake sent
data_done  out  1  1-cycle pulse: data packet sent
tx_error  out  1  1-cycle pulse: timeout or illegal size
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered (Moore). On reset, every output is 0 and the state is IDLE. Reset mid-packet abandons the packet silently, with no done or error pulse.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - hs_req=1: latch hs_type, go to START.
  - Else data_req=1 and data_size<=MAX_DATA: latch data_size, go to START.
  - Else data_req=1 and data_size>MAX_DATA: next cycle pulse data_grant and tx_error, stay IDLE (request dropped).
  - Handshake has strict priority over data when both are requested in the same cycle.
- START (exactly 1 cycle):
  - tx_packet = command code; the matching grant pulses in this same cycle.
  - tx_packet_data_size = latched size for DATA, 0 for handshakes.
  - Go to WAIT_DONE and clear the counter.
  - Latency from request to command: 1 cycle.
- WAIT_DONE:
  - tx_packet=0; tx_packet_data_size holds its value.
  - Counter increments each cycle.
  - tx_done=1: next cycle pulse hs_done or data_done, go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done: pulse tx_error, go to GAP.
  - tx_done on the same cycle as the final count counts as success; no error.
- GAP:
  - Counter counts IPG_CYCLES cycles, then go to IDLE.
  - Requests are ignored until IDLE; tx_done is ignored.
  - tx_packet_data_size is cleared to 0 on entry.
- tx_done in IDLE, START or GAP is ignored.
- data_size=0 is legal (zero-length packet).
- Requesters must deassert the request after its grant. A request still high in IDLE is treated as a new request.

Decomposition:
- Package usb_tx_pkg holds:
  - tx_packet code localparams (TX_NONE, TX_DATA, TX_ACK, TX_NAK)
  - the scheduler state enum
  - MAX_DATA default
- One sub-module: flex_counter (parameterised width, clear, count_enable, rollover_val, rollover_flag).
  - A single instance is shared by the timeout count and the gap count.
  - It is reloaded on every state entry.

Test Plan:
- hs_req=1, hs_type=1 in IDLE -> next cycle tx_packet=3 and hs_grant=1 for one cycle; tx_done after 40 cycles -> hs_done pulses 1 cycle later; busy stays high for 16 further cycles.
- data_req=1, data_size=64 -> tx_packet=1 for one cycle, tx_packet_data_size=64 held until tx_done; then data_done pulses.
- hs_req and data_req (size 8) asserted in the same cycle -> ACK/NAK issued first. DATA is issued exactly IPG_CYCLES+1 cycles after hs_done, provided data_req is still held.
- data_req, data_size=65 -> data_grant and tx_error pulse together; tx_packet stays 0 and busy stays 0.
- DATA started, tx_done never asserted -> tx_error pulses after 8192 cycles with no data_done; IDLE is reached 16 cycles later. Repeat with tx_done on the final cycle -> data_done pulses, no tx_error.
- Assert n_rst=0 during WAIT_DONE -> all outputs 0 asynchronously; after release, a new hs_req is served normally.
